multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore FSM that sequences a shared-ALU, shared-memory multi-cycle RV32I datapath: fetch, decode, execute, memory and writeback over several cycles per instruction.
- Drives every datapath mux select and write strobe, and derives ALUControl through an internal ALU-op decoder.
- Stalls on a memory ready handshake.
- Sits beside the datapath and replaces the single-cycle control path.
- Supported opcodes: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011, jal 1101111.

Parameters:
- RESET_STATE, FETCH, state entered on reset (kept as a parameter for bench override only).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op  in  7  opcode field from the instruction register.
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- zero_flag  in  1  ALU zero result, combinational from the datapath.
- mem_ready  in  1  memory has completed the access this cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction and OldPC register enable.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  ALU operand A select: 00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  out  2  ALU operand B select: 00 = rs2, 01 = Imm, 10 = constant 4.
- ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- RegWrite  out  1  register file write strobe.
- ALUControl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- illegal_instr  out  1  sticky flag: an unsupported opcode was decoded.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP. Single state register, asynchronous reset to FETCH.
- Output timing: all outputs are combinational decodes of the state, except the FETCH strobes, which are additionally gated by mem_ready. ImmSrc decodes op directly, independent of state.
- While rst_n = 0: PCWrite, IRWrite, MemWrite and RegWrite are forced to 0; illegal_instr = 0; all other outputs take their FETCH values.
- Defaults: every signal not listed for a state is 0.
- FETCH:
  - AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, ALUOp = add, ResultSrc = 10.
  - IRWrite = PCWrite = mem_ready.
  - Stay in FETCH while mem_ready = 0; go to DECODE when mem_ready = 1.
- DECODE:
  - ALUSrcA = 01, ALUSrcB = 01, ALUOp = add (branch target latched into ALUOut).
  - Next state by op: lw/sw -> MEMADR, R -> EXECR, I-ALU -> EXECI, beq -> BEQ, jal -> JAL, any other op -> TRAP.
- MEMADR: ALUSrcA = 10, ALUSrcB = 01, ALUOp = add. Next: lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD: AdrSrc = 1. Hold until mem_ready = 1, then MEMWB.
- MEMWB: ResultSrc = 01, RegWrite = 1. Next: FETCH.
- MEMWRITE: AdrSrc = 1, MemWrite = 1 held until mem_ready = 1, then FETCH. MemWrite must not drop before mem_ready.
- EXECR: ALUSrcA = 10, ALUSrcB = 00, ALUOp = funct-decoded. Next: ALUWB.
- EXECI: ALUSrcA = 10, ALUSrcB = 01, ALUOp = funct-decoded. Next: ALUWB.
- ALUWB: ResultSrc = 00, RegWrite = 1. Next: FETCH.
- BEQ:
  - ALUSrcA = 10, ALUSrcB = 00, ALUOp = sub, ResultSrc = 00.
  - PCWrite = zero_flag.
  - Next: FETCH.
- JAL:
  - ALUSrcA = 01, ALUSrcB = 10, ALUOp = add, ResultSrc = 00, PCWrite = 1 (PC <- target from ALUOut).
  - Next: ALUWB, which writes OldPC + 4 to rd.
- TRAP: all strobes 0, illegal_instr = 1. Absorbing state; only reset exits.
- ALU decode:
  - ALUOp add -> 000; ALUOp sub -> 001.
  - Funct-decoded: funct3 000 -> 001 if (op[5] & funct7b5), else 000; 010 -> 101; 110 -> 011; 111 -> 010; any other funct3 -> 000.
- Cycle counts with mem_ready tied to 1: lw 5, sw 4, R / I-ALU 4, beq 3, jal 4. Each stall cycle adds exactly one cycle.
- Reset asserted mid-instruction: state goes to FETCH and strobes drop in the same cycle, with no partial writes after the assertion edge.

Decomposition:
- Shared package (ctrl_pkg):
  - state enum;
  - opcode constants;
  - ALUOp enum {ADD, SUB, FUNCT};
  - ALUControl codes;
  - ResultSrc, ALUSrcA and ALUSrcB encodings.
- Sub-module alu_op_decoder: pure combinational; inputs ALUOp, funct3, op[5], funct7b5; output ALUControl.

Test Plan:
- lw, mem_ready = 1: states F-D-MA-MR-MWB across 5 cycles; RegWrite = 1 only in cycle 5 with ResultSrc = 01; IRWrite = 1 only in cycle 1.
- sw with mem_ready low for 3 cycles in MEMWRITE: MemWrite = 1 and AdrSrc = 1 held for 4 cycles; FETCH follows on the cycle after mem_ready = 1; RegWrite stays 0.
- R-type sub (funct3 000, funct7b5 = 1, op 0110011): ALUControl = 001 in EXECR. Same fields on I-ALU op 0010011: ALUControl = 000.
- beq with zero_flag = 1, then zero_flag = 0: PCWrite = 1, then 0, in the BEQ cycle; ALUControl = 001; 3 cycles each.
- Opcode 1111111: DECODE -> TRAP; illegal_instr = 1 and stays 1 with all strobes 0 for 10 cycles; rst_n pulse clears it and the FSM is in FETCH.
- rst_n asserted mid-ALUWB, asynchronously between edges: RegWrite drops immediately; after release the FSM starts in FETCH.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, opcodes,
// ALU op classes and the datapath mux select codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format is a pure function of the opcode; R-type has none.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   imm_src_of = IMM_S;
      OP_BEQ:  imm_src_of = IMM_B;
      OP_JAL:  imm_src_of = IMM_J;
      default: imm_src_of = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_op_decoder.sv
// Maps the FSM's ALU op class plus instruction funct fields onto ALUControl.
module alu_op_decoder
  import ctrl_pkg::*;
(
  input  aluop_t      i_aluop,
  input  logic [2:0]  i_funct3,
  input  logic        i_op5,
  input  logic        i_funct7b5,
  output logic [2:0]  o_alu_control
);

  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_aluop)
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          // funct7b5 selects sub only for R-type; on I-ALU it is imm bit 10.
          3'b000:  o_alu_control = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  o_alu_control = ALU_SLT;
          3'b110:  o_alu_control = ALU_OR;
          3'b111:  o_alu_control = ALU_AND;
          default: o_alu_control = ALU_ADD;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing a shared-ALU, shared-memory multi-cycle RV32I datapath;
// outputs decode the state, FETCH strobes are qualified by mem_ready.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero_flag,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [2:0] ALUControl,
  output logic       illegal_instr
);

  state_t r_state;
  state_t w_next;
  aluop_t w_aluop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RESET_STATE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_IALU:      w_next = S_EXECI;
          OP_BEQ:       w_next = S_BEQ;
          OP_JAL:       w_next = S_JAL;
          default:      w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        case (op)
          OP_LW:   w_next = S_MEMREAD;
          OP_SW:   w_next = S_MEMWRITE;
          default: w_next = S_TRAP;
        endcase
      end
      S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    w_next = S_ALUWB;
      S_EXECI:    w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BEQ:      w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_TRAP;
    endcase
  end

  always_comb begin
    PCWrite       = 1'b0;
    AdrSrc        = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    ResultSrc     = RES_ALUOUT;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_RS2;
    RegWrite      = 1'b0;
    w_aluop       = ALUOP_ADD;
    illegal_instr = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        // OldPC + imm parked in ALUOut as the branch target.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        w_aluop = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        w_aluop = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        w_aluop = ALUOP_SUB;
        PCWrite = zero_flag;
      end
      S_JAL: begin
        // ALU forms OldPC + 4 for rd while PC takes the target from ALUOut.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
      end
      S_TRAP:  illegal_instr = 1'b1;
      default: illegal_instr = 1'b1;
    endcase
    // Reset kills every write strobe combinationally, before the next edge.
    if (!rst_n) begin
      PCWrite       = 1'b0;
      IRWrite       = 1'b0;
      MemWrite      = 1'b0;
      RegWrite      = 1'b0;
      illegal_instr = 1'b0;
    end
  end

  alu_op_decoder u_alu_dec (
    .i_aluop       (w_aluop),
    .i_funct3      (funct3),
    .i_op5         (op[5]),
    .i_funct7b5    (funct7b5),
    .o_alu_control (ALUControl)
  );

  assign ImmSrc = imm_src_of(op);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: walks each instruction class cycle by cycle and compares the
// full output vector against hand-written per-state values.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero_flag;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_instr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero_flag(zero_flag), .mem_ready(mem_ready), .PCWrite(PCWrite),
    .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .ALUControl(ALUControl),
    .illegal_instr(illegal_instr)
  );

  // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,RegWrite,ALUControl,illegal}
  function automatic logic [14:0] v(input logic pcw, adr, mw, irw,
                                    input logic [1:0] rs, sa, sb,
                                    input logic rw, input logic [2:0] ac,
                                    input logic il);
    return {pcw, adr, mw, irw, rs, sa, sb, rw, ac, il};
  endfunction

  wire [14:0] outs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                      ALUSrcB, RegWrite, ALUControl, illegal_instr};

  logic [14:0] E_FETCH, E_FSTALL, E_DEC, E_MADR, E_MRD, E_MWB, E_MWR, E_ALUWB;
  logic [14:0] E_JAL, E_TRAP, E_RST;

  task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // Apply this cycle's inputs, check, then advance to just past the next edge.
  task automatic step(input string tag, input logic mr, input logic zf,
                      input logic [14:0] exp);
    mem_ready = mr;
    zero_flag = zf;
    #1;
    chk(tag, outs, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic run_alu(input string tag, input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input logic [2:0] ac);
    logic [14:0] e_ex;
    op = o; funct3 = f3; funct7b5 = f7;
    e_ex = v(0,0,0,0, 2'b00, 2'b10, (o == 7'b0110011) ? 2'b00 : 2'b01, 0, ac, 0);
    step({tag, "_F"}, 1, 0, E_FETCH);
    step({tag, "_D"}, 1, 0, E_DEC);
    step({tag, "_EX"}, 1, 0, e_ex);
    step({tag, "_WB"}, 1, 0, E_ALUWB);
  endtask

  initial begin
    E_FETCH  = v(1,0,0,1, 2'b10, 2'b00, 2'b10, 0, 3'b000, 0);
    E_FSTALL = v(0,0,0,0, 2'b10, 2'b00, 2'b10, 0, 3'b000, 0);
    E_RST    = E_FSTALL;
    E_DEC    = v(0,0,0,0, 2'b00, 2'b01, 2'b01, 0, 3'b000, 0);
    E_MADR   = v(0,0,0,0, 2'b00, 2'b10, 2'b01, 0, 3'b000, 0);
    E_MRD    = v(0,1,0,0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 0);
    E_MWB    = v(0,0,0,0, 2'b01, 2'b00, 2'b00, 1, 3'b000, 0);
    E_MWR    = v(0,1,1,0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 0);
    E_ALUWB  = v(0,0,0,0, 2'b00, 2'b00, 2'b00, 1, 3'b000, 0);
    E_JAL    = v(1,0,0,0, 2'b00, 2'b01, 2'b10, 0, 3'b000, 0);
    E_TRAP   = v(0,0,0,0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 1);

    rst_n = 1'b0; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0;
    zero_flag = 1'b0; mem_ready = 1'b1;
    #1;
    chk("reset_outputs", outs, E_RST);
    @(posedge clk); @(posedge clk); #1;
    chk("reset_hold", outs, E_RST);
    rst_n = 1'b1;

    // lw, no stalls: 5 cycles
    op = 7'b0000011;
    #1; chk2("imm_lw", ImmSrc, 2'b00);
    step("lw_F",   1, 0, E_FETCH);
    step("lw_D",   1, 0, E_DEC);
    step("lw_MA",  1, 0, E_MADR);
    step("lw_MR",  1, 0, E_MRD);
    step("lw_MWB", 1, 0, E_MWB);

    // sw with three wait cycles in MEMWRITE, then a stalled fetch
    op = 7'b0100011;
    #1; chk2("imm_sw", ImmSrc, 2'b01);
    step("sw_F",   1, 0, E_FETCH);
    step("sw_D",   1, 0, E_DEC);
    step("sw_MA",  1, 0, E_MADR);
    step("sw_MW0", 0, 0, E_MWR);
    step("sw_MW1", 0, 0, E_MWR);
    step("sw_MW2", 0, 0, E_MWR);
    step("sw_MW3", 1, 0, E_MWR);
    step("sw_next_fetch_stall", 0, 0, E_FSTALL);
    step("sw_fetch_stall2",     0, 0, E_FSTALL);

    // R-type sub vs I-ALU add with identical funct fields, plus other functs
    run_alu("r_sub",   7'b0110011, 3'b000, 1'b1, 3'b001);
    run_alu("i_add",   7'b0010011, 3'b000, 1'b1, 3'b000);
    run_alu("r_add",   7'b0110011, 3'b000, 1'b0, 3'b000);
    run_alu("i_slt",   7'b0010011, 3'b010, 1'b0, 3'b101);
    run_alu("r_or",    7'b0110011, 3'b110, 1'b0, 3'b011);
    run_alu("i_and",   7'b0010011, 3'b111, 1'b0, 3'b010);
    run_alu("r_other", 7'b0110011, 3'b001, 1'b1, 3'b000);

    // beq taken then not taken; funct3 set to a value that would decode as or
    op = 7'b1100011; funct3 = 3'b110;
    #1; chk2("imm_beq", ImmSrc, 2'b10);
    step("beq1_F",   1, 0, E_FETCH);
    step("beq1_D",   1, 0, E_DEC);
    step("beq1_BEQ", 1, 1, v(1,0,0,0, 2'b00, 2'b10, 2'b00, 0, 3'b001, 0));
    step("beq0_F",   1, 0, E_FETCH);
    step("beq0_D",   1, 1, E_DEC);
    step("beq0_BEQ", 1, 0, v(0,0,0,0, 2'b00, 2'b10, 2'b00, 0, 3'b001, 0));

    // jal: 4 cycles ending in ALUWB
    op = 7'b1101111;
    #1; chk2("imm_jal", ImmSrc, 2'b11);
    step("jal_F",   1, 0, E_FETCH);
    step("jal_D",   1, 0, E_DEC);
    step("jal_JAL", 1, 0, E_JAL);
    step("jal_WB",  1, 0, E_ALUWB);

    // illegal opcode: TRAP absorbs regardless of mem_ready/zero_flag
    op = 7'b1111111;
    step("trap_F", 1, 0, E_FETCH);
    step("trap_D", 1, 0, E_DEC);
    for (int i = 0; i < 10; i++) step("trap_hold", i[0], ~i[0], E_TRAP);
    rst_n = 1'b0;
    #1; chk("trap_reset_clears", outs, E_RST);
    @(posedge clk); #1;
    rst_n = 1'b1;
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
    step("trap_after_F", 1, 0, E_FETCH);
    step("trap_after_D", 1, 0, E_DEC);

    // reset mid-ALUWB, between clock edges
    step("rst_mid_EX", 1, 0, v(0,0,0,0, 2'b00, 2'b10, 2'b00, 0, 3'b000, 0));
    mem_ready = 1'b1;
    #1; chk("rst_mid_WB", outs, E_ALUWB);
    #1; rst_n = 1'b0;
    #1; chk("rst_mid_drop", outs, E_RST);
    @(posedge clk); #1;
    chk("rst_mid_hold", outs, E_RST);
    rst_n = 1'b1;
    step("rst_mid_after_F", 1, 0, E_FETCH);
    step("rst_mid_after_D", 1, 0, E_DEC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
